// File: rtl/part3_demux_buf_if.sv
// rtl/part3_demux_buf_if.sv - byte source, select and four-channel consumer bundle
interface part3_demux_buf_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [1:0]       S;
  logic             auto_rr;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] L;
  logic [WIDTH-1:0] M;
  logic [3:0]       vld;
  logic [3:0]       ack;
  logic [1:0]       rr_ptr;
  logic [7:0]       xfer_cnt;

  // Environment side: drives the byte stream, select and acks.
  modport master (
    output din, din_valid, S, auto_rr, ack,
    input  din_ready, J, K, L, M, vld, rr_ptr, xfer_cnt
  );

  // Distributor side.
  modport slave (
    input  din, din_valid, S, auto_rr, ack,
    output din_ready, J, K, L, M, vld, rr_ptr, xfer_cnt
  );
endinterface

// File: rtl/part3_demux_buf.sv
// rtl/part3_demux_buf.sv - registered 1-to-4 byte distributor with per-channel valid/ack
module part3_demux_buf #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  part3_demux_buf_if.slave bus
);

  logic [1:0]       target;
  logic             accept;
  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       vld_q;
  logic [1:0]       rr_q;
  logic [7:0]       cnt_q;

  // Pick the target channel and decide whether the byte on din can land this cycle.
  // A same-cycle ack on the target frees its slot, so a busy channel being drained
  // still accepts back-to-back without a bubble.
  always_comb begin
    target = bus.auto_rr ? rr_q : bus.S;
    bus.din_ready = ~vld_q[target] | bus.ack[target];
    accept = bus.din_valid & bus.din_ready;
  end

  // Holding registers, valid flags, round-robin pointer and transfer counter.
  // A new byte on a channel wins over its ack so vld stays high; otherwise an ack clears vld
  // and leaves the data register untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
      vld_q <= 4'b0000;
      rr_q  <= 2'd0;
      cnt_q <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (target == 2'(i))) begin
          data_q[i] <= bus.din;
          vld_q[i]  <= 1'b1;
        end else if (bus.ack[i]) begin
          vld_q[i]  <= 1'b0;
        end
      end
      if (accept) begin
        cnt_q <= cnt_q + 8'd1;
        if (bus.auto_rr) begin
          rr_q <= rr_q + 2'd1;
        end
      end
    end
  end

  // Drive registered state onto the bundle.
  always_comb begin
    bus.J        = data_q[0];
    bus.K        = data_q[1];
    bus.L        = data_q[2];
    bus.M        = data_q[3];
    bus.vld      = vld_q;
    bus.rr_ptr   = rr_q;
    bus.xfer_cnt = cnt_q;
  end

endmodule
